// File: rtl/fc_tx_scheduler.sv
// FC transmit word scheduler: merges user frames, R_RDY primitives and primitive
// fill onto one 36-bit word path, enforcing inter-frame gap and BB credit.
module fc_tx_scheduler #(
  parameter int          MIN_GAP   = 6,
  parameter logic [31:0] RRDY_WORD = 32'hBC954A4A,
  parameter int          CREDIT_W  = 8
) (
  input  logic                tx_clk,
  input  logic                reset,
  input  logic                link_active,
  input  logic [CREDIT_W-1:0] bb_credit_init,
  input  logic                rrdy_rx,
  input  logic                rrdy_tx_req,
  input  logic [31:0]         prim_data,
  input  logic [3:0]          prim_datak,
  input  logic [31:0]         usertx_data,
  input  logic                usertx_valid,
  output logic                usertx_ready,
  input  logic                usertx_startofpacket,
  input  logic                usertx_endofpacket,
  output logic [35:0]         avtx_data,
  output logic [CREDIT_W-1:0] credit_count,
  output logic [3:0]          rrdy_pending,
  output logic [31:0]         frames_sent,
  output logic [15:0]         frames_aborted,
  output logic [15:0]         underruns
);

  localparam int              GAP_W   = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);
  localparam logic [3:0]      K_CTRL  = 4'b1000;

  typedef enum logic [1:0] {
    ST_GAP,
    ST_READY,
    ST_FRAME,
    ST_FLUSH
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;
  logic             link_q;

  logic             rrdy_avail;
  logic             can_start;
  logic             discard_ok;
  logic             emit_rrdy;
  logic             start_frame;
  logic             accept;
  logic [35:0]      prim_word;
  logic [35:0]      rrdy_word;
  logic [35:0]      frame_word;

  assign prim_word  = {prim_datak, prim_data};
  assign rrdy_word  = {K_CTRL, RRDY_WORD};
  assign frame_word = {(usertx_startofpacket || usertx_endofpacket) ? K_CTRL : 4'b0000,
                       usertx_data};

  assign rrdy_avail = link_active && (rrdy_pending != 4'd0);
  assign can_start  = link_active && usertx_valid && usertx_startofpacket &&
                      (credit_count != '0) && (rrdy_pending == 4'd0);
  // Outside a frame, stray non-SOF words are dropped; a blocked SOF is held.
  assign discard_ok = usertx_valid && (!link_active || !usertx_startofpacket);
  assign gap_next   = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + 1'b1;
  assign accept     = usertx_valid && usertx_ready;

  always_comb begin
    usertx_ready = 1'b0;
    emit_rrdy    = 1'b0;
    start_frame  = 1'b0;
    case (state)
      ST_GAP: begin
        emit_rrdy    = rrdy_avail;
        usertx_ready = discard_ok;
      end
      ST_READY: begin
        if (rrdy_avail) begin
          emit_rrdy    = 1'b1;
          usertx_ready = discard_ok;
        end else if (can_start) begin
          start_frame  = 1'b1;
          usertx_ready = 1'b1;
        end else begin
          usertx_ready = discard_ok;
        end
      end
      ST_FRAME: usertx_ready = link_active;
      ST_FLUSH: usertx_ready = 1'b1;
      default:  usertx_ready = 1'b0;
    endcase
    if (reset) begin
      usertx_ready = 1'b0;
      emit_rrdy    = 1'b0;
      start_frame  = 1'b0;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state          <= ST_GAP;
      gap_cnt        <= '0;
      link_q         <= 1'b0;
      avtx_data      <= prim_word;
      credit_count   <= '0;
      rrdy_pending   <= 4'd0;
      frames_sent    <= 32'd0;
      frames_aborted <= 16'd0;
      underruns      <= 16'd0;
    end else begin
      link_q <= link_active;

      // Credit is reloaded from login on the link-up edge and forced to 0 while down.
      if (!link_active) begin
        credit_count <= '0;
      end else if (!link_q) begin
        credit_count <= bb_credit_init;
      end else if (rrdy_rx && !start_frame) begin
        if (credit_count != '1) credit_count <= credit_count + 1'b1;
      end else if (start_frame && !rrdy_rx) begin
        if (credit_count != '0) credit_count <= credit_count - 1'b1;
      end

      if (!link_active) begin
        rrdy_pending <= 4'd0;
      end else if (rrdy_tx_req && !emit_rrdy) begin
        if (rrdy_pending != 4'd15) rrdy_pending <= rrdy_pending + 4'd1;
      end else if (emit_rrdy && !rrdy_tx_req) begin
        rrdy_pending <= rrdy_pending - 4'd1;
      end

      case (state)
        ST_GAP: begin
          avtx_data <= emit_rrdy ? rrdy_word : prim_word;
          gap_cnt   <= gap_next;
          if (gap_next == GAP_MAX) state <= ST_READY;
        end
        ST_READY: begin
          if (emit_rrdy) begin
            avtx_data <= rrdy_word;
          end else if (start_frame) begin
            avtx_data <= frame_word;
            if (usertx_endofpacket) begin
              frames_sent <= frames_sent + 32'd1;
              gap_cnt     <= '0;
              state       <= ST_GAP;
            end else begin
              state <= ST_FRAME;
            end
          end else begin
            avtx_data <= prim_word;
          end
        end
        ST_FRAME: begin
          if (!link_active) begin
            avtx_data <= prim_word;
            state     <= ST_FLUSH;
          end else if (usertx_valid) begin
            avtx_data <= frame_word;
            if (usertx_endofpacket) begin
              frames_sent <= frames_sent + 32'd1;
              gap_cnt     <= '0;
              state       <= ST_GAP;
            end
          end else begin
            avtx_data <= prim_word;
            if (underruns != 16'hFFFF) underruns <= underruns + 16'd1;
          end
        end
        ST_FLUSH: begin
          avtx_data <= prim_word;
          if (accept && usertx_endofpacket) begin
            frames_aborted <= frames_aborted + 16'd1;
            gap_cnt        <= '0;
            state          <= ST_GAP;
          end
        end
        default: begin
          avtx_data <= prim_word;
          gap_cnt   <= '0;
          state     <= ST_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_tx_scheduler.sv
// Cycle-accurate bench for fc_tx_scheduler: per-cycle vectors with expected
// ready and an expected-word scoreboard for the 1-cycle avtx_data path.
module tb_fc_tx_scheduler;

  localparam logic [1:0] S_PRIM = 2'd0;
  localparam logic [1:0] S_RRDY = 2'd1;
  localparam logic [1:0] S_USER = 2'd2;

  logic        tx_clk = 1'b0;
  logic        reset;
  logic        link_active;
  logic [7:0]  bb_credit_init;
  logic        rrdy_rx;
  logic        rrdy_tx_req;
  logic [31:0] prim_data;
  logic [3:0]  prim_datak;
  logic [31:0] usertx_data;
  logic        usertx_valid;
  logic        usertx_ready;
  logic        usertx_startofpacket;
  logic        usertx_endofpacket;
  logic [35:0] avtx_data;
  logic [7:0]  credit_count;
  logic [3:0]  rrdy_pending;
  logic [31:0] frames_sent;
  logic [15:0] frames_aborted;
  logic [15:0] underruns;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  logic [36:0] sb_q[$];

  typedef struct {
    bit          rst;
    bit          link;
    bit          valid;
    bit          sop;
    bit          eop;
    logic [31:0] data;
    bit          rx;
    bit          treq;
    bit          rdy;
    logic [1:0]  src;
  } vec_t;

  vec_t tbl[$];

  fc_tx_scheduler dut (
    .tx_clk               (tx_clk),
    .reset                (reset),
    .link_active          (link_active),
    .bb_credit_init       (bb_credit_init),
    .rrdy_rx              (rrdy_rx),
    .rrdy_tx_req          (rrdy_tx_req),
    .prim_data            (prim_data),
    .prim_datak           (prim_datak),
    .usertx_data          (usertx_data),
    .usertx_valid         (usertx_valid),
    .usertx_ready         (usertx_ready),
    .usertx_startofpacket (usertx_startofpacket),
    .usertx_endofpacket   (usertx_endofpacket),
    .avtx_data            (avtx_data),
    .credit_count         (credit_count),
    .rrdy_pending         (rrdy_pending),
    .frames_sent          (frames_sent),
    .frames_aborted       (frames_aborted),
    .underruns            (underruns)
  );

  always #5 tx_clk = ~tx_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit link, bit valid, bit sop, bit eop,
                              logic [31:0] data, bit rx, bit treq, bit rdy, logic [1:0] src);
    vec_t v;
    v.rst = rst; v.link = link; v.valid = valid; v.sop = sop; v.eop = eop;
    v.data = data; v.rx = rx; v.treq = treq; v.rdy = rdy; v.src = src;
    return v;
  endfunction

  function automatic vec_t fl(bit link, bit rx, bit treq, logic [1:0] src);
    return mk(1'b0, link, 1'b0, 1'b0, 1'b0, 32'h0, rx, treq, 1'b0, src);
  endfunction

  function automatic vec_t wd(bit link, bit sop, bit eop, logic [31:0] data,
                              bit treq, bit rdy, logic [1:0] src);
    return mk(1'b0, link, 1'b1, sop, eop, data, 1'b0, treq, rdy, src);
  endfunction

  // Drive one cycle, check combinational ready, then compare the registered word.
  task automatic apply_vec(input vec_t v, input string tag);
    logic [36:0] exp;
    reset                = v.rst;
    link_active          = v.link;
    usertx_valid         = v.valid;
    usertx_startofpacket = v.sop;
    usertx_endofpacket   = v.eop;
    usertx_data          = v.data;
    rrdy_rx              = v.rx;
    rrdy_tx_req          = v.treq;
    prim_data            = 32'h5000_0000 + cyc;
    prim_datak           = {3'b100, cyc[0]};
    #1;
    check({tag, " ready"}, {63'd0, usertx_ready}, {63'd0, v.rdy});
    case (v.src)
      S_PRIM:  exp = {1'b1, prim_datak, prim_data};
      S_RRDY:  exp = {1'b1, 4'b1000, 32'hBC954A4A};
      S_USER:  exp = {1'b1, (v.sop || v.eop) ? 4'b1000 : 4'b0000, v.data};
      default: exp = 37'd0;
    endcase
    sb_q.push_back(exp);
    @(posedge tx_clk);
    #1;
    exp = sb_q.pop_front();
    if (exp[36]) check({tag, " avtx"}, {28'd0, avtx_data}, {28'd0, exp[35:0]});
    cyc = cyc + 32'd1;
  endtask

  initial begin
    bb_credit_init = 8'd2;

    // Scenario 1: credit 2, three back-to-back 4-word frames.
    for (int i = 0; i < 8; i++) tbl.push_back(fl(1, 0, 0, S_PRIM));
    tbl.push_back(wd(1, 1, 0, 32'h1100_0001, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 0, 32'h1100_0002, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 0, 32'h1100_0003, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 1, 32'h1100_0004, 0, 1, S_USER));
    for (int i = 0; i < 6; i++) tbl.push_back(wd(1, 1, 0, 32'h2200_0001, 0, 0, S_PRIM));
    tbl.push_back(wd(1, 1, 0, 32'h2200_0001, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 0, 32'h2200_0002, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 0, 32'h2200_0003, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 1, 32'h2200_0004, 0, 1, S_USER));
    for (int i = 0; i < 9; i++) tbl.push_back(wd(1, 1, 0, 32'h3300_0001, 0, 0, S_PRIM));
    tbl.push_back(mk(0, 1, 1, 1, 0, 32'h3300_0001, 1, 0, 0, S_PRIM));
    tbl.push_back(wd(1, 1, 0, 32'h3300_0001, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 0, 32'h3300_0002, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 0, 32'h3300_0003, 0, 1, S_USER));
    tbl.push_back(wd(1, 0, 1, 32'h3300_0004, 0, 1, S_USER));

    // Reset state.
    apply_vec(mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, S_PRIM), "rst0");
    apply_vec(mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, S_PRIM), "rst1");
    check("rst credit", credit_count, 0);
    check("rst pending", rrdy_pending, 0);
    check("rst frames_sent", frames_sent, 0);
    check("rst aborted", frames_aborted, 0);
    check("rst underruns", underruns, 0);

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));
    check("s1 frames_sent", frames_sent, 3);
    check("s1 credit", credit_count, 0);

    // Scenario 2: R_RDY requested mid-frame goes out right after EOF.
    apply_vec(fl(1, 1, 0, S_PRIM), "s2 gap");
    for (int i = 0; i < 5; i++) apply_vec(fl(1, 0, 0, S_PRIM), "s2 gap");
    apply_vec(wd(1, 1, 0, 32'h4400_0001, 0, 1, S_USER), "s2 w1");
    apply_vec(wd(1, 0, 0, 32'h4400_0002, 1, 1, S_USER), "s2 w2");
    apply_vec(wd(1, 0, 0, 32'h4400_0003, 0, 1, S_USER), "s2 w3");
    apply_vec(wd(1, 0, 1, 32'h4400_0004, 0, 1, S_USER), "s2 w4");
    check("s2 pending before", rrdy_pending, 1);
    apply_vec(fl(1, 0, 0, S_RRDY), "s2 rrdy");
    check("s2 pending after", rrdy_pending, 0);
    apply_vec(fl(1, 1, 0, S_PRIM), "s2 gap2");
    for (int i = 0; i < 4; i++) apply_vec(fl(1, 0, 0, S_PRIM), "s2 gap2");
    check("s2 frames_sent", frames_sent, 4);

    // Credit 1 with rrdy_rx and start together, then a 2-cycle underrun.
    apply_vec(mk(0, 1, 1, 1, 0, 32'h5500_0001, 1, 0, 1, S_USER), "s5 w1");
    check("s5 credit", credit_count, 1);
    apply_vec(wd(1, 0, 0, 32'h5500_0002, 0, 1, S_USER), "s4 w2");
    apply_vec(mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 1, S_PRIM), "s4 ur1");
    apply_vec(mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 1, S_PRIM), "s4 ur2");
    apply_vec(wd(1, 0, 0, 32'h5500_0003, 0, 1, S_USER), "s4 w3");
    apply_vec(wd(1, 0, 1, 32'h5500_0004, 0, 1, S_USER), "s4 w4");
    check("s4 underruns", underruns, 2);
    check("s4 frames_sent", frames_sent, 5);
    for (int i = 0; i < 6; i++) apply_vec(fl(1, 0, 0, S_PRIM), "s4 gap");

    // Scenario 3: link drops as word 4 of an 8-word frame is presented.
    apply_vec(wd(1, 1, 0, 32'h6600_0001, 0, 1, S_USER), "s3 w1");
    apply_vec(wd(1, 0, 0, 32'h6600_0002, 0, 1, S_USER), "s3 w2");
    apply_vec(wd(1, 0, 0, 32'h6600_0003, 0, 1, S_USER), "s3 w3");
    apply_vec(wd(0, 0, 0, 32'h6600_0004, 0, 0, S_PRIM), "s3 drop");
    for (int i = 4; i <= 8; i++)
      apply_vec(wd(0, 0, (i == 8), 32'h6600_0000 + i, 0, 1, S_PRIM), $sformatf("s3 flush%0d", i));
    check("s3 aborted", frames_aborted, 1);
    check("s3 frames_sent", frames_sent, 5);

    // Scenario 6: R_RDY requests ignored while down, saturate at 15 inside a frame.
    for (int i = 0; i < 20; i++) apply_vec(fl(0, 0, 1, S_PRIM), "s6 down");
    check("s6 pending down", rrdy_pending, 0);
    apply_vec(fl(1, 0, 0, S_PRIM), "s6 up");
    check("s6 credit load", credit_count, 2);
    apply_vec(wd(1, 1, 0, 32'h7700_0000, 0, 1, S_USER), "s6 sof");
    for (int i = 1; i <= 20; i++)
      apply_vec(wd(1, 0, 0, 32'h7700_0000 + i, 1, 1, S_USER), $sformatf("s6 w%0d", i));
    check("s6 pending sat", rrdy_pending, 15);
    apply_vec(wd(1, 0, 1, 32'h7700_00FF, 0, 1, S_USER), "s6 eof");
    for (int i = 0; i < 15; i++) apply_vec(fl(1, 0, 0, S_RRDY), $sformatf("s6 rrdy%0d", i));
    check("s6 pending drained", rrdy_pending, 0);
    check("s6 frames_sent", frames_sent, 6);

    // Scenario 7: reset asserted mid-frame.
    apply_vec(wd(1, 1, 0, 32'h8800_0001, 0, 1, S_USER), "s7 w1");
    apply_vec(wd(1, 0, 0, 32'h8800_0002, 0, 1, S_USER), "s7 w2");
    apply_vec(mk(1, 1, 1, 0, 0, 32'h8800_0003, 0, 0, 0, S_PRIM), "s7 rst");
    check("s7 credit", credit_count, 0);
    check("s7 pending", rrdy_pending, 0);
    check("s7 frames_sent", frames_sent, 0);
    check("s7 aborted", frames_aborted, 0);
    check("s7 underruns", underruns, 0);
    apply_vec(fl(1, 0, 0, S_PRIM), "s7 post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
